hazard_ctrl: RTL and testbench

- Central hazard controller for the 5-stage MIPS pipeline.
- Generates the EX-stage forwarding selects (ForwardAE/ForwardBE) that drive the EX operand muxes, and the ID-stage branch-compare forwards.
- Detects load-use and branch-operand hazards; produces stall/flush controls.
- Sequences the multi-cycle divider: holds the pipeline for DIV_CYCLES and releases it exactly once per divide.

---
 rtl/hazard_ctrl_pkg.sv | 53 +++++
 rtl/hazard_ctrl_div_sequencer.sv | 85 ++++++++
 rtl/hazard_ctrl.sv | 102 ++++++++++
 tb/tb_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types, constants and match helpers for the MIPS pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam logic        RESETABLE  = 1'b0;
  localparam int unsigned DATALENGTH = 32;
  localparam logic [DATALENGTH-1:0] ZEROWORD = '0;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  typedef enum logic [FWD_W-1:0] {
    FWD_RD  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic flush_e;
  } stall_ctrl_t;

  // A writing stage hits a source register; r0 is hard-wired and never matches.
  function automatic logic reg_hit(input logic             we,
                                   input logic [REG_W-1:0] wr,
                                   input logic [REG_W-1:0] src);
    return we && (wr != '0) && (wr == src);
  endfunction

  // EX operand select: the younger MEM result wins over WB.
  function automatic fwd_sel_e ex_fwd(input logic             we_m,
                                      input logic [REG_W-1:0] wr_m,
                                      input logic             we_w,
                                      input logic [REG_W-1:0] wr_w,
                                      input logic [REG_W-1:0] src);
    fwd_sel_e sel;
    sel = FWD_RD;
    if (reg_hit(we_m, wr_m, src)) begin
      sel = FWD_MEM;
    end else if (reg_hit(we_w, wr_w, src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_div_sequencer.sv
// Multi-cycle divider sequencer: holds EX for DIV_CYCLES cycles and pulses done once.
module hazard_ctrl_div_sequencer
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic i_div_e,
  output logic o_div_stall,
  output logic o_div_busy,
  output logic o_div_done
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clock) begin
    if (reset == RESETABLE) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // BUSY leaves once the decremented count reaches zero, giving DIV_CYCLES-2 BUSY cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      DIV_IDLE: begin
        if (i_div_e) begin
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = (CNT_LOAD == '0) ? DIV_DONE : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        w_cnt_nxt = (r_cnt == '0) ? '0 : (r_cnt - CNT_ONE);
        if (r_cnt <= CNT_ONE) begin
          w_state_nxt = DIV_DONE;
        end
      end
      DIV_DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = DIV_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = DIV_IDLE;
      end
    endcase
  end

  always_comb begin
    o_div_stall = 1'b0;
    o_div_busy  = 1'b0;
    o_div_done  = 1'b0;
    case (r_state)
      DIV_IDLE: begin
        o_div_stall = i_div_e;
        o_div_busy  = i_div_e;
      end
      DIV_BUSY: begin
        o_div_stall = 1'b1;
        o_div_busy  = 1'b1;
      end
      DIV_DONE: begin
        o_div_busy  = 1'b1;
        o_div_done  = 1'b1;
      end
      default: begin
        o_div_stall = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding selects, stalls/flush, divider hold.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             JumpRegD,
  input  logic             DivE,
  output logic [FWD_W-1:0] ForwardAE,
  output logic [FWD_W-1:0] ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushE,
  output logic             DivBusy,
  output logic             DivDone
);

  logic        w_in_reset;
  fwd_sel_e    w_fwd_ae;
  fwd_sel_e    w_fwd_be;
  logic        w_fwd_ad;
  logic        w_fwd_bd;
  logic        w_lwstall;
  logic        w_br_use;
  logic        w_br_hit_e;
  logic        w_br_hit_m;
  logic        w_brstall;
  logic        w_divstall;
  logic        w_div_busy;
  logic        w_div_done;
  stall_ctrl_t w_stall;

  assign w_in_reset = (reset == RESETABLE);

  hazard_ctrl_div_sequencer #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_div_sequencer (
    .clock       (clock),
    .reset       (reset),
    .i_div_e     (DivE),
    .o_div_stall (w_divstall),
    .o_div_busy  (w_div_busy),
    .o_div_done  (w_div_done)
  );

  assign w_fwd_ae = ex_fwd(RegWriteM, WriteRegM, RegWriteW, WriteRegW, RsE);
  assign w_fwd_be = ex_fwd(RegWriteM, WriteRegM, RegWriteW, WriteRegW, RtE);
  assign w_fwd_ad = reg_hit(RegWriteM, WriteRegM, RsD);
  assign w_fwd_bd = reg_hit(RegWriteM, WriteRegM, RtD);

  assign w_lwstall = MemtoRegE &&
                     (reg_hit(RegWriteE, WriteRegE, RsD) || reg_hit(RegWriteE, WriteRegE, RtD));

  // JR/JALR only reads rs; a branch compares both rs and rt in ID.
  assign w_br_use   = BranchD || JumpRegD;
  assign w_br_hit_e = reg_hit(RegWriteE, WriteRegE, RsD) ||
                      (BranchD && reg_hit(RegWriteE, WriteRegE, RtD));
  assign w_br_hit_m = reg_hit(MemtoRegM, WriteRegM, RsD) ||
                      (BranchD && reg_hit(MemtoRegM, WriteRegM, RtD));
  assign w_brstall  = w_br_use && (w_br_hit_e || w_br_hit_m);

  // A divide in EX must never be flushed; its stall dominates the bubble.
  always_comb begin
    w_stall         = '0;
    w_stall.stall_f = w_lwstall | w_brstall | w_divstall;
    w_stall.stall_d = w_lwstall | w_brstall | w_divstall;
    w_stall.stall_e = w_divstall;
    w_stall.flush_e = (w_lwstall | w_brstall) & ~w_divstall;
  end

  assign ForwardAE = w_in_reset ? FWD_RD : w_fwd_ae;
  assign ForwardBE = w_in_reset ? FWD_RD : w_fwd_be;
  assign ForwardAD = ~w_in_reset & w_fwd_ad;
  assign ForwardBD = ~w_in_reset & w_fwd_bd;
  assign StallF    = ~w_in_reset & w_stall.stall_f;
  assign StallD    = ~w_in_reset & w_stall.stall_d;
  assign StallE    = ~w_in_reset & w_stall.stall_e;
  assign FlushE    = ~w_in_reset & w_stall.flush_e;
  assign DivBusy   = ~w_in_reset & w_div_busy;
  assign DivDone   = ~w_in_reset & w_div_done;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: forwarding, load-use, branch, divide, reset.
module tb_hazard_ctrl;

  localparam int unsigned DIV_CYCLES = 32;

  logic       clock;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MemtoRegM;
  logic       BranchD, JumpRegD, DivE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD;
  logic       StallF, StallD, StallE, FlushE;
  logic       DivBusy, DivDone;

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(6)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .RsD       (RsD),
    .RtD       (RtD),
    .RsE       (RsE),
    .RtE       (RtE),
    .WriteRegE (WriteRegE),
    .WriteRegM (WriteRegM),
    .WriteRegW (WriteRegW),
    .RegWriteE (RegWriteE),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .MemtoRegE (MemtoRegE),
    .MemtoRegM (MemtoRegM),
    .BranchD   (BranchD),
    .JumpRegD  (JumpRegD),
    .DivE      (DivE),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .ForwardAD (ForwardAD),
    .ForwardBD (ForwardBD),
    .StallF    (StallF),
    .StallD    (StallD),
    .StallE    (StallE),
    .FlushE    (FlushE),
    .DivBusy   (DivBusy),
    .DivDone   (DivDone)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0;
    BranchD = 1'b0; JumpRegD = 1'b0; DivE = 1'b0;
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow #1 later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clr();
    reset = 1'b0;
    tick();
    tick();

    // Reset forces every output low even with active hazards on the inputs.
    RsE = 5'd5; RegWriteM = 1'b1; WriteRegM = 5'd5; RsD = 5'd5; DivE = 1'b1;
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd5;
    #1;
    chk("rst_fae",   ForwardAE, 2'b00);
    chk("rst_fad",   ForwardAD, 1'b0);
    chk("rst_stallf", StallF,   1'b0);
    chk("rst_stalle", StallE,   1'b0);
    chk("rst_flushe", FlushE,   1'b0);
    chk("rst_busy",  DivBusy,   1'b0);
    tick();
    clr();
    reset = 1'b1;
    #1;
    chk("idle_stallf", StallF, 1'b0);
    chk("idle_busy",   DivBusy, 1'b0);

    // EX forwarding priority and r0 exclusion.
    tick();
    RsE = 5'd5; RtE = 5'd5;
    RegWriteM = 1'b1; WriteRegM = 5'd5; RegWriteW = 1'b1; WriteRegW = 5'd5;
    #1;
    chk("fwd_mem_a", ForwardAE, 2'b10);
    chk("fwd_mem_b", ForwardBE, 2'b10);
    RegWriteM = 1'b0;
    #1;
    chk("fwd_wb_a", ForwardAE, 2'b01);
    chk("fwd_wb_b", ForwardBE, 2'b01);
    RegWriteM = 1'b1; WriteRegM = 5'd0; WriteRegW = 5'd0; RsE = 5'd0; RtE = 5'd0;
    #1;
    chk("fwd_r0_a", ForwardAE, 2'b00);
    chk("fwd_r0_b", ForwardBE, 2'b00);
    WriteRegM = 5'd7; RsE = 5'd7; RtE = 5'd9; RsD = 5'd7; RtD = 5'd9;
    #1;
    chk("fwd_split_a", ForwardAE, 2'b10);
    chk("fwd_split_b", ForwardBE, 2'b00);
    chk("fwd_ad",      ForwardAD, 1'b1);
    chk("fwd_bd_miss", ForwardBD, 1'b0);

    // Load-use: one stall+bubble, then the consumer forwards from WB.
    tick();
    clr();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
    #1;
    chk("lw_stallf", StallF, 1'b1);
    chk("lw_stalld", StallD, 1'b1);
    chk("lw_flushe", FlushE, 1'b1);
    chk("lw_stalle", StallE, 1'b0);
    tick();
    clr();
    MemtoRegM = 1'b1; RegWriteM = 1'b1; WriteRegM = 5'd8; RsD = 5'd8;
    #1;
    chk("lw_m_stallf", StallF, 1'b0);
    chk("lw_m_flushe", FlushE, 1'b0);
    tick();
    clr();
    RegWriteW = 1'b1; WriteRegW = 5'd8; RsE = 5'd8;
    #1;
    chk("lw_w_fae", ForwardAE, 2'b01);
    clr();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd0;
    #1;
    chk("lw_r0_stallf", StallF, 1'b0);

    // Branch operand hazards.
    tick();
    clr();
    BranchD = 1'b1; RtD = 5'd3; RegWriteE = 1'b1; WriteRegE = 5'd3;
    #1;
    chk("br_e_stallf", StallF, 1'b1);
    chk("br_e_flushe", FlushE, 1'b1);
    tick();
    RegWriteE = 1'b0; WriteRegE = 5'd0;
    RegWriteM = 1'b1; WriteRegM = 5'd3; MemtoRegM = 1'b0;
    #1;
    chk("br_m_stallf", StallF, 1'b0);
    chk("br_m_fbd",    ForwardBD, 1'b1);
    clr();
    JumpRegD = 1'b1; RsD = 5'd4; RtD = 5'd3; RegWriteE = 1'b1; WriteRegE = 5'd3;
    #1;
    chk("jr_rt_nostall", StallF, 1'b0);
    RsD = 5'd3;
    #1;
    chk("jr_rs_stall", StallF, 1'b1);
    clr();
    BranchD = 1'b1; RsD = 5'd9; MemtoRegM = 1'b1; RegWriteM = 1'b1; WriteRegM = 5'd9;
    #1;
    chk("br_lwm_stall", StallF, 1'b1);

    // Divide with DivE held high for the whole occupancy.
    tick();
    clr();
    DivE = 1'b1;
    for (int k = 0; k < DIV_CYCLES; k++) begin
      if (k != 0) tick();
      #1;
      chk("div_stallf", StallF,  (k <= DIV_CYCLES - 2) ? 1'b1 : 1'b0);
      chk("div_stalle", StallE,  (k <= DIV_CYCLES - 2) ? 1'b1 : 1'b0);
      chk("div_busy",   DivBusy, 1'b1);
      chk("div_done",   DivDone, (k == DIV_CYCLES - 1) ? 1'b1 : 1'b0);
    end
    tick();
    DivE = 1'b0;
    #1;
    chk("div_after_busy", DivBusy, 1'b0);
    chk("div_after_done", DivDone, 1'b0);
    chk("div_after_stall", StallF, 1'b0);

    // Divide overlapping a persistent load-use.
    tick();
    clr();
    DivE = 1'b1; MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
    for (int k = 0; k < DIV_CYCLES; k++) begin
      if (k != 0) tick();
      #1;
      chk("ovl_stalle", StallE, (k <= DIV_CYCLES - 2) ? 1'b1 : 1'b0);
      chk("ovl_flushe", FlushE, (k <= DIV_CYCLES - 2) ? 1'b0 : 1'b1);
      chk("ovl_stallf", StallF, 1'b1);
    end
    tick();
    clr();
    #1;
    chk("ovl_after_busy", DivBusy, 1'b0);

    // Reset in the middle of a divide: no completion pulse afterwards.
    tick();
    DivE = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    reset = 1'b0;
    #1;
    chk("rmid_busy",  DivBusy, 1'b0);
    chk("rmid_stall", StallF,  1'b0);
    tick();
    reset = 1'b1;
    DivE = 1'b0;
    #1;
    chk("rmid_post_busy",  DivBusy, 1'b0);
    chk("rmid_post_stall", StallE,  1'b0);
    for (int k = 0; k < DIV_CYCLES + 4; k++) begin
      tick();
      #1;
      chk("rmid_no_done", DivDone, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
